// File: rtl/divider_sequencer_pkg.sv
// Shared types and constants for the divider sequencer.
// Optional status outputs are enabled by defining DIVSEQ_STATUS_EN.
package divseq_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [31:0] DIV_MIN      = 32'd2;
   localparam int          ENTRY_HOLD_W = 16;

   typedef struct packed {
      logic [31:0]             divider;
      logic [ENTRY_HOLD_W-1:0] hold;
   } entry_t;

   // Keeps the downstream (div/2)-1 computation from underflowing.
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage

// File: rtl/divider_sequencer_if.sv
// Control/status bundle between board logic and the divider sequencer.
// Status signals exist only when DIVSEQ_STATUS_EN is defined.
interface divider_sequencer_if #(
   parameter int DEPTH  = 8,
   parameter int HOLD_W = 16
);
   localparam int AW = $clog2(DEPTH);

   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [31:0]       wr_divider;
   logic [HOLD_W-1:0] wr_hold;
   logic [AW:0]       seq_len;
   logic              loop;
   logic              start;
   logic              stop;
   logic [31:0]       divider;
   logic              busy;
   logic              done;
`ifdef DIVSEQ_STATUS_EN
   logic [AW-1:0]     step_idx;
   logic              step_pulse;

   modport master (
      output wr_en, wr_addr, wr_divider, wr_hold, seq_len, loop, start, stop,
      input  divider, busy, done, step_idx, step_pulse
   );
   modport slave (
      input  wr_en, wr_addr, wr_divider, wr_hold, seq_len, loop, start, stop,
      output divider, busy, done, step_idx, step_pulse
   );
`else
   modport master (
      output wr_en, wr_addr, wr_divider, wr_hold, seq_len, loop, start, stop,
      input  divider, busy, done
   );
   modport slave (
      input  wr_en, wr_addr, wr_divider, wr_hold, seq_len, loop, start, stop,
      output divider, busy, done
   );
`endif
endinterface

// File: rtl/divider_sequencer_edge_sync.sv
// Brings the divided clock into the system domain and emits a one-cycle pulse
// per rising edge; the pulse appears three clk cycles after the rise.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_pulse
);
   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_pulse;

   // Two-stage synchronizer, delayed copy, and registered rise detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_meta  <= i_async;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_pulse <= r_sync & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;
endmodule

// File: rtl/divider_sequencer.sv
// Steps the clock divider through a programmable (divider, hold) table, each entry
// held for a number of div_clk rising edges. Define DIVSEQ_STATUS_EN for step status.
module divider_sequencer
   import divseq_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter int          AW       = $clog2(DEPTH),
   parameter int          HOLD_W   = ENTRY_HOLD_W,
   parameter logic [31:0] IDLE_DIV = 32'd50000000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             div_clk,
   divider_sequencer_if.slave bus
);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   entry_t            r_tbl [DEPTH];
   state_t            r_state, w_state_nx;
   logic [AW-1:0]     r_idx, w_idx_nx;
   logic [AW:0]       r_len, w_len_nx;
   logic [HOLD_W-1:0] r_cnt, w_cnt_nx;
   logic [HOLD_W-1:0] r_hold, w_hold_nx;
   logic [31:0]       r_div, w_div_nx;
   logic              r_done, w_done_nx;
   logic              w_load;
   logic [AW-1:0]     w_load_idx;
   logic              w_edge;
   entry_t            w_entry;

   edge_sync u_edge_sync (
      .clk     (clk_in),
      .rst     (rst),
      .i_async (div_clk),
      .o_pulse (w_edge)
   );

   // Table write port; contents are deliberately left unreset.
   always_ff @(posedge clk_in) begin
      if (bus.wr_en) begin
         r_tbl[bus.wr_addr] <= '{divider: bus.wr_divider, hold: ENTRY_HOLD_W'(bus.wr_hold)};
      end else begin
         r_tbl[bus.wr_addr] <= r_tbl[bus.wr_addr];
      end
   end

   assign w_entry = r_tbl[w_load_idx];

   // Next-state logic: stop beats start, start beats edge handling.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_len_nx   = r_len;
      w_cnt_nx   = r_cnt;
      w_hold_nx  = r_hold;
      w_div_nx   = r_div;
      w_done_nx  = 1'b0;
      w_load     = 1'b0;
      w_load_idx = r_idx;

      if (bus.stop) begin
         w_state_nx = IDLE;
         w_idx_nx   = '0;
         w_cnt_nx   = '0;
         w_div_nx   = IDLE_DIV;
      end else if (bus.start) begin
         w_state_nx = RUN;
         w_load     = 1'b1;
         w_load_idx = '0;
         if (bus.seq_len == '0) begin
            w_len_nx = (AW+1)'(1);
         end else if (bus.seq_len > LEN_MAX) begin
            w_len_nx = LEN_MAX;
         end else begin
            w_len_nx = bus.seq_len;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_div_nx = IDLE_DIV;
            end
            RUN: begin
               if (w_edge) begin
                  if ((r_cnt + HOLD_W'(1)) == r_hold) begin
                     if (({1'b0, r_idx} + (AW+1)'(1)) < r_len) begin
                        w_load     = 1'b1;
                        w_load_idx = r_idx + AW'(1);
                     end else if (bus.loop) begin
                        w_load     = 1'b1;
                        w_load_idx = '0;
                     end else begin
                        w_state_nx = IDLE;
                        w_idx_nx   = '0;
                        w_cnt_nx   = '0;
                        w_div_nx   = IDLE_DIV;
                        w_done_nx  = 1'b1;
                     end
                  end else begin
                     w_cnt_nx = r_cnt + HOLD_W'(1);
                  end
               end else begin
                  w_cnt_nx = r_cnt;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_div_nx   = IDLE_DIV;
            end
         endcase
      end

      // Hold is captured at load so table rewrites never disturb the active entry.
      if (w_load) begin
         w_idx_nx  = w_load_idx;
         w_cnt_nx  = '0;
         w_div_nx  = clamp_div(w_entry.divider);
         w_hold_nx = (w_entry.hold == '0) ? HOLD_W'(1) : HOLD_W'(w_entry.hold);
      end else begin
         w_hold_nx = r_hold;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len   <= (AW+1)'(1);
         r_cnt   <= '0;
         r_hold  <= HOLD_W'(1);
         r_div   <= IDLE_DIV;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_len   <= w_len_nx;
         r_cnt   <= w_cnt_nx;
         r_hold  <= w_hold_nx;
         r_div   <= w_div_nx;
         r_done  <= w_done_nx;
      end
   end

   assign bus.divider = r_div;
   assign bus.busy    = (r_state == RUN);
   assign bus.done    = r_done;

`ifdef DIVSEQ_STATUS_EN
   logic r_step_pulse;

   // Marks every entry load, including the first after start.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_step_pulse <= 1'b0;
      end else begin
         r_step_pulse <= w_load;
      end
   end

   assign bus.step_idx   = r_idx;
   assign bus.step_pulse = r_step_pulse;
`endif
endmodule
